// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory stage for lw/lb/lbu/sw/sb with req/ready handshake
// Optional: define LSU_MISALIGN_CHECK_EN to reject word accesses with address[1:0] != 0.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [31:0]           loadData,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWdata,
  output logic [3:0]            memWstrb,
  input  logic                  memReady,
  input  logic [31:0]           memRdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state, state_next;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic        err_q;
  logic        accept;
  logic        access_ok;
  logic [7:0]  lane_byte;
  logic [31:0] load_ext;

  assign busy   = (state != IDLE);
  assign memReq = (state == REQ);
  assign done   = (state == RESP);
  assign error  = (state == RESP) && err_q;
  assign accept = (state == IDLE) && start && (memRead || memWrite);

  // memWrite takes priority, so an lbu encoding with memWrite set is a bad store
  always_comb begin
    access_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                ((funct3 == 3'b100) && !memWrite);
`ifdef LSU_MISALIGN_CHECK_EN
    if ((funct3 == 3'b010) && (address[1:0] != 2'b00)) begin
      access_ok = 1'b0;
    end
`else
`endif
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = access_ok ? REQ : RESP;
      REQ:  if (memReady) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lane_byte = 8'h00;
    case (lane_q)
      2'd0: lane_byte = memRdata[7:0];
      2'd1: lane_byte = memRdata[15:8];
      2'd2: lane_byte = memRdata[23:16];
      2'd3: lane_byte = memRdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_ext = {24'h000000, lane_byte};
      default: load_ext = memRdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      funct3_q <= 3'b000;
      lane_q   <= 2'b00;
      err_q    <= 1'b0;
      loadData <= 32'h0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= 32'h0;
      memWstrb <= 4'b0000;
    end else begin
      state <= state_next;
      if (accept) begin
        funct3_q <= funct3;
        lane_q   <= address[1:0];
        err_q    <= !access_ok;
        // Rejected accesses leave the memory-side outputs untouched
        if (access_ok) begin
          memAddr <= {address[ADDR_WIDTH-1:2], 2'b00};
          memWe   <= memWrite;
          if (!memWrite) begin
            memWdata <= 32'h0;
            memWstrb <= 4'b0000;
          end else if (funct3 == 3'b010) begin
            memWdata <= writeData;
            memWstrb <= 4'b1111;
          end else begin
            memWdata <= {4{writeData[7:0]}};
            memWstrb <= 4'b0001 << address[1:0];
          end
        end
      end
      if ((state == REQ) && memReady && !memWe) begin
        loadData <= load_ext;
      end
    end
  end

endmodule
